score_board: RTL and testbench
==============================

// Module: score_board
// PURPOSE
// Two-player score keeper and 7-segment renderer for pong. Holds per-player BCD scores,
// detects the winning score, and paints both scores into the frame from the beam position.
// Sits between game logic (point pulses) and the video mixer (score_display OR'd into RGB).
// PARAMETERS
// DIGITS       2     BCD digits per player (1..3)
// WIN_SCORE    11    score that ends a game (1 .. 10**DIGITS-1)
// LEFT_X       128   hpos of left score's leftmost digit cell
// RIGHT_X      320   hpos of right score's leftmost digit cell
// SCORE_Y      16    vpos of top row of both scores
// DIGIT_PITCH  24    horizontal distance between digit cells (>=16)
// BLINK_LOG2   4     winner blink period = 2**BLINK_LOG2 frames per phase
// PORTS
// clk          in   1          pixel clock
// reset        in   1          asynchronous, active-high
// hpos         in   9          beam column
// vpos         in   9          beam row
// point_left   in   1          1-cycle pulse: left player scores
// point_right  in   1          1-cycle pulse: right player scores
// new_game     in   1          1-cycle pulse: clear scores, start play
// left_bcd     out  4*DIGITS   left score, BCD, digit 0 = LSBs
// right_bcd    out  4*DIGITS   right score, BCD
// game_over    out  1          high in GAME_OVER state
// winner       out  1          0 = left, 1 = right; valid while game_over
// score_display out 1          registered pixel-on for score graphics
// BEHAVIOUR
// - Reset (async): state IDLE, scores 0, game_over 0, winner 0, score_display 0, blink cnt 0.
// - FSM: IDLE --new_game--> PLAYING --score==WIN_SCORE--> GAME_OVER --new_game--> PLAYING.
//   new_game in any state clears both scores and winner same edge; state -> PLAYING.
// - Points counted only in PLAYING; ignored in IDLE/GAME_OVER and in the new_game cycle.
// - BCD increment: digit 9 -> 0 with carry; at all-9s the score saturates (no wrap).
// - point_left & point_right same cycle: both increment. If both reach WIN_SCORE
//   together, winner = 0 (left priority). Otherwise winner = the player at WIN_SCORE.
// - left_bcd/right_bcd/game_over/winner update on the edge that samples the pulse
//   (visible next cycle).
// - Frame tick = (hpos==0 && vpos==0); blink counter (BLINK_LOG2+1 bits) increments per tick,
//   cleared on entering GAME_OVER. Blink phase = counter MSB.
// - Digit cell: 16 wide x 32 tall at (X + k*DIGIT_PITCH, SCORE_Y), k=0 most significant digit.
//   With cx = hpos-cellX (0..15), cy = vpos-SCORE_Y (0..31), segments lit when:
//   a: cy<4            b: cx>=12 & cy<16     c: cx>=12 & cy>=16     d: cy>=28
//   e: cx<4 & cy>=16   f: cx<4 & cy<16       g: 14<=cy<=17
//   (each AND'd with the digit's segment decode; standard 0-9 patterns, 6/7/9 with tails;
//   codes A-F never occur).
// - Leading-zero blanking: a leading zero digit is blank unless it is the units digit
//   (score 0 shows "0", 7 shows " 7").
// - IDLE: both scores drawn (show 0). PLAYING: both drawn. GAME_OVER: loser drawn steadily,
//   winner drawn only when blink phase = 0.
// - score_display registered: reflects hpos/vpos of the previous cycle (latency 1).
// - Pixels outside all cells: 0. Cells never overlap (DIGIT_PITCH>=16 enforced by assertion).
// TESTING
// 1 reset mid-frame -> score_display=0, bcd=0, game_over=0 immediately, before next clk edge.
// 2 new_game, 11 point_left pulses -> left_bcd=8'h11, game_over=1, winner=0; 12th pulse ignored.
// 3 new_game, left and right pulsed together 11x -> both 8'h11, game_over=1, winner=0.
// 4 WIN_SCORE=99, DIGITS=2: 9 pulses -> 8'h09, 10th -> 8'h10 (carry); one more after win -> no change.
// 5 score 7, beam at (LEFT_X+DIGIT_PITCH+1, SCORE_Y+1) -> score_display=1 next cycle (seg a);
//   tens cell at (LEFT_X+1, SCORE_Y+1) -> 0 (blanked leading zero).
// 6 GAME_OVER, right wins: right digits toggle every 16 frames, left digits steady;
//   new_game -> scores 0, game_over=0, display steady.

Source files
------------

// File: rtl/score_board.sv
// score_board: two-player BCD score keeper for pong with win detection and 7-segment score rendering.
module score_board #(
    parameter int DIGITS      = 2,
    parameter int WIN_SCORE   = 11,
    parameter int LEFT_X      = 128,
    parameter int RIGHT_X     = 320,
    parameter int SCORE_Y     = 16,
    parameter int DIGIT_PITCH = 24,
    parameter int BLINK_LOG2  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          hpos,
    input  logic [8:0]          vpos,
    input  logic                point_left,
    input  logic                point_right,
    input  logic                new_game,
    output logic [4*DIGITS-1:0] left_bcd,
    output logic [4*DIGITS-1:0] right_bcd,
    output logic                game_over,
    output logic                winner,
    output logic                score_display
);
    localparam int W = 4 * DIGITS;

    if (DIGIT_PITCH < 16) begin : g_pitch_check
        $error("DIGIT_PITCH must be at least 16 so digit cells cannot overlap");
    end

    typedef enum logic [1:0] {IDLE, PLAYING, GAME_OVER} state_t;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int n;
        r = '0;
        n = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam logic [W-1:0] MAX_BCD = to_bcd(10**DIGITS - 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic c;
        r = s;
        c = 1'b1;
        if (s == MAX_BCD) return s;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                r[4*i +: 4] = (s[4*i +: 4] == 4'd9) ? 4'd0 : s[4*i +: 4] + 4'd1;
                c = (s[4*i +: 4] == 4'd9);
            end
        end
        return r;
    endfunction

    // Segment order {a,b,c,d,e,f,g}; 6, 7 and 9 are drawn with tails.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110010;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic cell_on(input logic [W-1:0] s, input int x0, input int k, input int h, input int v);
        int cx, cy;
        logic [6:0] m;
        cx = h - x0 - k * DIGIT_PITCH;
        cy = v - SCORE_Y;
        if (cx < 0 || cx > 15 || cy < 0 || cy > 31) return 1'b0;
        if (k != DIGITS - 1 && (s >> (4 * (DIGITS - 1 - k))) == '0) return 1'b0;
        m = seg_decode(s[4*(DIGITS-1-k) +: 4]);
        return (m[6] && cy < 4) || (m[5] && cx >= 12 && cy < 16) || (m[4] && cx >= 12 && cy >= 16) ||
               (m[3] && cy >= 28) || (m[2] && cx < 4 && cy >= 16) || (m[1] && cx < 4 && cy < 16) ||
               (m[0] && cy >= 14 && cy <= 17);
    endfunction

    state_t state;
    logic [BLINK_LOG2:0] blink;
    logic [W-1:0] next_left, next_right;
    logic tick, win_now, show_left, show_right, pix;

    assign tick       = (hpos == 9'd0) && (vpos == 9'd0);
    assign next_left  = point_left ? bcd_inc(left_bcd) : left_bcd;
    assign next_right = point_right ? bcd_inc(right_bcd) : right_bcd;
    assign win_now    = (state == PLAYING) && !new_game && (next_left == WIN_BCD || next_right == WIN_BCD);
    assign show_left  = !(state == GAME_OVER && !winner && blink[BLINK_LOG2]);
    assign show_right = !(state == GAME_OVER && winner && blink[BLINK_LOG2]);

    always_comb begin
        pix = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            pix = pix | (show_left && cell_on(left_bcd, LEFT_X, k, int'(hpos), int'(vpos)))
                      | (show_right && cell_on(right_bcd, RIGHT_X, k, int'(hpos), int'(vpos)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            left_bcd      <= '0;
            right_bcd     <= '0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
            blink         <= '0;
            score_display <= 1'b0;
        end else begin
            score_display <= pix;
            blink         <= win_now ? '0 : blink + (BLINK_LOG2 + 1)'(tick);
            if (new_game) begin
                state     <= PLAYING;
                left_bcd  <= '0;
                right_bcd <= '0;
                winner    <= 1'b0;
                game_over <= 1'b0;
            end else if (state == PLAYING) begin
                left_bcd  <= next_left;
                right_bcd <= next_right;
                if (win_now) begin
                    state     <= GAME_OVER;
                    game_over <= 1'b1;
                    winner    <= (next_left != WIN_BCD);
                end
            end
        end
    end
endmodule

// File: tb/tb_score_board.sv
// tb_score_board: random and directed checks of score_board against an integer-score reference model.
module tb_score_board;
    logic clk, reset, point_left, point_right, new_game;
    logic [8:0] hpos, vpos;
    logic [7:0] lb [2];
    logic [7:0] rb [2];
    logic go [2];
    logic wn [2];
    logic sd [2];

    int checks = 0;
    int errors = 0;

    // model state per instance: scores, state (0 idle, 1 playing, 2 over), winner, blink count
    int ml [2], mr [2], ms [2], mw [2], mb [2];
    int win [2] = '{11, 99};

    localparam bit [6:0] SEGS [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                       7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

    score_board u_dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .point_left(point_left), .point_right(point_right), .new_game(new_game),
        .left_bcd(lb[0]), .right_bcd(rb[0]), .game_over(go[0]), .winner(wn[0]), .score_display(sd[0])
    );

    score_board #(.WIN_SCORE(99)) u_dut99 (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .point_left(point_left), .point_right(point_right), .new_game(new_game),
        .left_bcd(lb[1]), .right_bcd(rb[1]), .game_over(go[1]), .winner(wn[1]), .score_display(sd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic bit m_pix(input int h, input int v, input int sl, input int sr, input int st, input int w, input int bk);
        bit on = 1'b0;
        for (int p = 0; p < 2; p++) begin
            int s = p ? sr : sl;
            int x0 = p ? 320 : 128;
            if (st == 2 && w == p && bk >= 16) continue;
            for (int k = 0; k < 2; k++) begin
                int cx = h - x0 - 24 * k;
                int cy = v - 16;
                int pw = (k == 0) ? 10 : 1;
                bit [6:0] g;
                if (cx < 0 || cx > 15 || cy < 0 || cy > 31) continue;
                if (k == 0 && s < 10) continue;
                g = SEGS[(s / pw) % 10];
                on |= (g[6] && cy < 4) || (g[5] && cx >= 12 && cy < 16) || (g[4] && cx >= 12 && cy >= 16) ||
                      (g[3] && cy >= 28) || (g[2] && cx < 4 && cy >= 16) || (g[1] && cx < 4 && cy < 16) ||
                      (g[0] && cy >= 14 && cy <= 17);
            end
        end
        return on;
    endfunction

    task automatic m_step(input int i, input bit pl, input bit pr, input bit ng, input bit tk);
        bit enter = 1'b0;
        if (ng) begin
            ml[i] = 0; mr[i] = 0; mw[i] = 0; ms[i] = 1;
        end else if (ms[i] == 1) begin
            if (pl && ml[i] < 99) ml[i]++;
            if (pr && mr[i] < 99) mr[i]++;
            if (ml[i] == win[i] || mr[i] == win[i]) begin
                ms[i] = 2;
                mw[i] = (ml[i] == win[i]) ? 0 : 1;
                enter = 1'b1;
            end
        end
        mb[i] = enter ? 0 : (mb[i] + int'(tk)) % 32;
    endtask

    task automatic cyc(input bit pl, input bit pr, input bit ng, input int h, input int v);
        bit ep [2];
        point_left = pl; point_right = pr; new_game = ng;
        hpos = 9'(h); vpos = 9'(v);
        for (int i = 0; i < 2; i++) ep[i] = m_pix(h, v, ml[i], mr[i], ms[i], mw[i], mb[i]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) m_step(i, pl, pr, ng, h == 0 && v == 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("left_bcd%0d", i), int'(lb[i]), bcd(ml[i]));
            check($sformatf("right_bcd%0d", i), int'(rb[i]), bcd(mr[i]));
            check($sformatf("game_over%0d", i), int'(go[i]), int'(ms[i] == 2));
            check($sformatf("winner%0d", i), int'(wn[i]), mw[i]);
            check($sformatf("display%0d h=%0d v=%0d", i, h, v), int'(sd[i]), int'(ep[i]));
        end
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_display%0d", i), int'(sd[i]), 0);
            check($sformatf("rst_left%0d", i), int'(lb[i]), 0);
            check($sformatf("rst_right%0d", i), int'(rb[i]), 0);
            check($sformatf("rst_game_over%0d", i), int'(go[i]), 0);
            ml[i] = 0; mr[i] = 0; ms[i] = 0; mw[i] = 0; mb[i] = 0;
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; point_left = 0; point_right = 0; new_game = 0; hpos = 9'd100; vpos = 9'd100;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("init_left", int'(lb[i]), 0);
            check("init_game_over", int'(go[i]), 0);
            check("init_display", int'(sd[i]), 0);
        end
        reset = 1'b0;
        // idle shows 0 in the units cell
        cyc(0, 0, 0, 128 + 24 + 13, 17);
        check("idle_zero", int'(sd[0]), 1);

        // left wins alone
        cyc(0, 0, 1, 100, 100);
        for (int n = 0; n < 11; n++) cyc(1, 0, 0, 100, 100);
        check("left_win_bcd", int'(lb[0]), 'h11);
        check("left_win_over", int'(go[0]), 1);
        check("left_win_winner", int'(wn[0]), 0);
        cyc(1, 0, 0, 100, 100);
        check("left_after_win", int'(lb[0]), 'h11);

        // simultaneous points: left priority
        cyc(0, 0, 1, 100, 100);
        for (int n = 0; n < 11; n++) cyc(1, 1, 0, 100, 100);
        check("tie_left", int'(lb[0]), 'h11);
        check("tie_right", int'(rb[0]), 'h11);
        check("tie_over", int'(go[0]), 1);
        check("tie_winner", int'(wn[0]), 0);

        // carry and saturation on the WIN_SCORE=99 instance
        cyc(0, 0, 1, 100, 100);
        for (int n = 0; n < 9; n++) cyc(1, 0, 0, 100, 100);
        check("carry_09", int'(lb[1]), 'h09);
        cyc(1, 0, 0, 100, 100);
        check("carry_10", int'(lb[1]), 'h10);
        for (int n = 10; n < 99; n++) cyc(1, 0, 0, 100, 100);
        check("win99_bcd", int'(lb[1]), 'h99);
        check("win99_over", int'(go[1]), 1);
        cyc(1, 0, 0, 100, 100);
        check("win99_hold", int'(lb[1]), 'h99);

        // score 7: segment a lit in units cell, tens blanked
        cyc(0, 0, 1, 100, 100);
        for (int n = 0; n < 7; n++) cyc(1, 0, 0, 100, 100);
        cyc(0, 0, 0, 128 + 24 + 1, 17);
        check("seven_seg_a", int'(sd[0]), 1);
        cyc(0, 0, 0, 128 + 1, 17);
        check("seven_tens_blank", int'(sd[0]), 0);

        // right wins; its digits blink with 16-frame phases, left stays steady
        cyc(0, 0, 1, 100, 100);
        for (int n = 0; n < 11; n++) cyc(0, 1, 0, 100, 100);
        check("right_win_winner", int'(wn[0]), 1);
        for (int f = 1; f <= 40; f++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 320 + 24 + 13, 17);
            check($sformatf("blink_right f=%0d", f), int'(sd[0]), int'(((f / 16) % 2) == 0));
            cyc(0, 0, 0, 128 + 24 + 13, 17);
            check($sformatf("steady_left f=%0d", f), int'(sd[0]), 1);
        end
        cyc(0, 0, 1, 100, 100);
        check("ng_left", int'(lb[0]), 0);
        check("ng_right", int'(rb[0]), 0);
        check("ng_over", int'(go[0]), 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 320 + 24 + 13, 17);
        check("ng_steady", int'(sd[0]), 1);

        // random play against the model, with an asynchronous reset part way through
        for (int n = 0; n < 3000; n++) begin
            bit ng = ($urandom_range(0, 149) == 0);
            bit pl = ($urandom_range(0, 3) == 0);
            bit pr = ($urandom_range(0, 3) == 0);
            int h, v;
            if ($urandom_range(0, 19) == 0) begin
                h = 0; v = 0;
            end else begin
                h = ($urandom_range(0, 1) ? 128 : 320) - 4 + int'($urandom_range(0, 56));
                v = 13 + int'($urandom_range(0, 38));
            end
            cyc(pl, pr, ng, h, v);
            if (n == 1500) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
